// File: rtl/spi_ram_ctrl_if.sv
// Word-level link between the SPI slave shifter and the command decoder / RAM.
// master drives command words; slave returns read data and the busy-drop pulse.
interface spi_ram_ctrl_if;
  logic [9:0] din;
  logic       rx_valid;
  logic [7:0] dout;
  logic       tx_valid;
  logic       err;

  modport master (
    output din,
    output rx_valid,
    input  dout,
    input  tx_valid,
    input  err
  );

  modport slave (
    input  din,
    input  rx_valid,
    output dout,
    output tx_valid,
    output err
  );
endinterface

// File: rtl/spi_ram_ctrl.sv
// Command decoder and single-port RAM behind the SPI slave: address/data writes,
// address-set reads, and a read-out window of TX_HOLD cycles on tx_valid.
module spi_ram_ctrl #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int TX_HOLD   = 8
) (
  input  logic           clk,
  input  logic           rstn,
  spi_ram_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(TX_HOLD + 1);

  typedef enum logic {
    IDLE = 1'b0,
    TX   = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_t;

  logic [7:0]           mem [MEM_DEPTH];

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic                 tx_valid_reg, tx_valid_next;
  logic                 err_reg, err_next;
  logic [ADDR_SIZE-1:0] wr_addr_reg, wr_addr_next;
  logic [ADDR_SIZE-1:0] rd_addr_reg, rd_addr_next;
  logic [7:0]           dout_reg;
  logic                 rx_valid_q_reg;

  logic                 accept;
  cmd_t                 cmd;
  logic [7:0]           payload;
  logic                 is_rd_data;
  logic                 mem_we;
  logic                 rd_load;

  // A word is taken only on the rising edge of rx_valid; the slave may hold it.
  assign accept     = bus.rx_valid && !rx_valid_q_reg;
  assign cmd        = cmd_t'(bus.din[9:8]);
  assign payload    = bus.din[7:0];
  assign is_rd_data = accept && (cmd == CMD_RD_DATA);

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    tx_valid_next = tx_valid_reg;
    err_next      = 1'b0;
    wr_addr_next  = wr_addr_reg;
    rd_addr_next  = rd_addr_reg;
    mem_we        = 1'b0;
    rd_load       = 1'b0;

    if (accept) begin
      case (cmd)
        CMD_WR_ADDR: wr_addr_next = payload;
        CMD_WR_DATA: begin
          mem_we       = 1'b1;
          wr_addr_next = wr_addr_reg + 1'b1;
        end
        CMD_RD_ADDR: rd_addr_next = payload;
        default:     ;
      endcase
    end

    case (state_reg)
      IDLE: begin
        if (is_rd_data) begin
          rd_load       = 1'b1;
          rd_addr_next  = rd_addr_reg + 1'b1;
          cnt_next      = CNT_W'(TX_HOLD);
          tx_valid_next = 1'b1;
          state_next    = TX;
        end
      end
      TX: begin
        if (cnt_reg == CNT_W'(1)) begin
          cnt_next      = '0;
          tx_valid_next = 1'b0;
          state_next    = IDLE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
        // A read request while shifting out is dropped and flagged.
        if (is_rd_data) begin
          err_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      tx_valid_reg   <= 1'b0;
      err_reg        <= 1'b0;
      wr_addr_reg    <= '0;
      rd_addr_reg    <= '0;
      rx_valid_q_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      tx_valid_reg   <= tx_valid_next;
      err_reg        <= err_next;
      wr_addr_reg    <= wr_addr_next;
      rd_addr_reg    <= rd_addr_next;
      rx_valid_q_reg <= bus.rx_valid;
    end
  end

  // RAM contents survive reset; only the write port is gated by accept.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_addr_reg] <= payload;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      dout_reg <= '0;
    end else if (rd_load) begin
      dout_reg <= mem[rd_addr_reg];
    end
  end

  assign bus.dout     = dout_reg;
  assign bus.tx_valid = tx_valid_reg;
  assign bus.err      = err_reg;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Bench for spi_ram_ctrl: every cycle is checked against a time-based model
// (read windows tracked by start cycle), plus a vector table and corner sequences.
module tb_spi_ram_ctrl;

  localparam int TX_HOLD = 8;

  logic clk = 1'b0;
  logic rstn;

  spi_ram_ctrl_if bus ();

  spi_ram_ctrl #(
    .MEM_DEPTH (256),
    .ADDR_SIZE (8),
    .TX_HOLD   (TX_HOLD)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: memory array, pointers, and the cycle the current read began.
  logic [7:0] m_mem [256];
  logic [7:0] m_wr, m_rd, m_dout;
  logic       m_prev, m_err, m_txact, m_tx;
  int         m_cyc = 0;
  int         m_tx_start = 0;

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, m_cyc);
    end
  endtask

  task automatic model_edge(input logic r, input logic [9:0] d, input logic v);
    logic busy;
    logic acc;
    m_cyc++;
    if (!r) begin
      m_dout = 8'h00; m_txact = 1'b0; m_err = 1'b0;
      m_wr = 8'h00; m_rd = 8'h00; m_prev = 1'b0; m_tx = 1'b0;
      return;
    end
    busy   = m_txact && ((m_cyc - 1 - m_tx_start) < TX_HOLD);
    acc    = v && !m_prev;
    m_prev = v;
    m_err  = 1'b0;
    if (acc) begin
      case (d[9:8])
        2'b00: m_wr = d[7:0];
        2'b01: begin m_mem[m_wr] = d[7:0]; m_wr = m_wr + 8'd1; end
        2'b10: m_rd = d[7:0];
        default: begin
          if (busy) m_err = 1'b1;
          else begin
            m_dout = m_mem[m_rd];
            m_rd = m_rd + 8'd1;
            m_txact = 1'b1;
            m_tx_start = m_cyc;
          end
        end
      endcase
    end
    m_tx = m_txact && ((m_cyc - m_tx_start) < TX_HOLD);
  endtask

  task automatic step(input logic r, input logic [9:0] d, input logic v);
    rstn = r;
    bus.din = d;
    bus.rx_valid = v;
    @(posedge clk);
    model_edge(r, d, v);
    #1;
    cmp("dout", bus.dout, m_dout);
    cmp("tx_valid", {7'b0, bus.tx_valid}, {7'b0, m_tx});
    cmp("err", {7'b0, bus.err}, {7'b0, m_err});
  endtask

  task automatic apply_word(input logic [9:0] d, input int hold, input int gap);
    for (int i = 0; i < hold; i++) step(1'b1, d, 1'b1);
    for (int i = 0; i < gap; i++) step(1'b1, d, 1'b0);
    $display("word cmd=%b data=%h hold=%0d -> dout=%h tx_valid=%b", d[9:8], d[7:0], hold,
             bus.dout, bus.tx_valid);
  endtask

  typedef struct {
    logic [9:0] din;
    int         hold;
    int         gap;
    logic       chk;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs [16];

  initial begin
    int tx_cnt;
    logic [9:0] rd;

    // Scenario table: write/read, auto-increment wrap, held rx_valid edge detect.
    vecs[0]  = '{10'h012, 3, 1, 1'b0, 8'h00};
    vecs[1]  = '{10'h1AB, 3, 1, 1'b0, 8'h00};
    vecs[2]  = '{10'h212, 3, 1, 1'b0, 8'h00};
    vecs[3]  = '{10'h300, 3, 8, 1'b1, 8'hAB};
    vecs[4]  = '{10'h0FF, 3, 1, 1'b0, 8'h00};
    vecs[5]  = '{10'h111, 3, 1, 1'b0, 8'h00};
    vecs[6]  = '{10'h122, 3, 1, 1'b0, 8'h00};
    vecs[7]  = '{10'h2FF, 3, 1, 1'b0, 8'h00};
    vecs[8]  = '{10'h300, 3, 8, 1'b1, 8'h11};
    vecs[9]  = '{10'h300, 3, 8, 1'b1, 8'h22};
    vecs[10] = '{10'h003, 3, 1, 1'b0, 8'h00};
    vecs[11] = '{10'h155, 10, 1, 1'b0, 8'h00};
    vecs[12] = '{10'h203, 3, 1, 1'b0, 8'h00};
    vecs[13] = '{10'h300, 3, 8, 1'b1, 8'h55};
    vecs[14] = '{10'h300, 3, 8, 1'b1, 8'h5E};
    vecs[15] = '{10'h166, 2, 1, 1'b0, 8'h00};

    // Reset with random inputs
    for (int i = 0; i < 2; i++) step(1'b0, 10'($urandom), 1'($urandom));
    cmp("rst_dout", bus.dout, 8'h00);
    cmp("rst_tx_valid", {7'b0, bus.tx_valid}, 8'h00);

    // Fill the RAM with a known pattern: mem[i] = i ^ 0x5A
    apply_word(10'h000, 1, 1);
    for (int i = 0; i < 256; i++) begin
      step(1'b1, {2'b01, 8'(i) ^ 8'h5A}, 1'b1);
      step(1'b1, {2'b01, 8'(i) ^ 8'h5A}, 1'b0);
    end
    $display("ram filled with pattern");

    foreach (vecs[k]) begin
      apply_word(vecs[k].din, vecs[k].hold, vecs[k].gap);
      if (vecs[k].chk) cmp($sformatf("vec%0d_dout", k), bus.dout, vecs[k].exp_dout);
    end
    // wr_addr landed on 4 after the held write
    apply_word(10'h204, 2, 1);
    apply_word(10'h300, 2, 9);
    cmp("wr_addr_after_hold", bus.dout, 8'h66);

    // Busy drop: second RD_DATA three cycles into the window
    apply_word(10'h240, 2, 1);
    step(1'b1, 10'h300, 1'b1);
    tx_cnt = 1;
    cmp("rd_start", {7'b0, bus.tx_valid}, 8'h01);
    step(1'b1, 10'h300, 1'b0); tx_cnt += bus.tx_valid;
    step(1'b1, 10'h300, 1'b0); tx_cnt += bus.tx_valid;
    step(1'b1, 10'h300, 1'b1); tx_cnt += bus.tx_valid;
    cmp("busy_err", {7'b0, bus.err}, 8'h01);
    step(1'b1, 10'h300, 1'b0); tx_cnt += bus.tx_valid;
    cmp("err_one_cycle", {7'b0, bus.err}, 8'h00);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 10'h300, 1'b0);
      tx_cnt += bus.tx_valid;
    end
    cmp("tx_len", 8'(tx_cnt), 8'd8);
    cmp("drop_dout", bus.dout, 8'h1A);
    apply_word(10'h300, 2, 9);
    cmp("rd_advanced_once", bus.dout, 8'h1B);
    $display("busy drop sequence done, window=%0d", tx_cnt);

    // Reset during the 4th cycle of tx_valid
    apply_word(10'h250, 2, 1);
    step(1'b1, 10'h300, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 10'h300, 1'b0);
    step(1'b0, 10'h300, 1'b0);
    cmp("rst_mid_tx", {7'b0, bus.tx_valid}, 8'h00);
    step(1'b1, 10'h300, 1'b0);
    cmp("rst_mid_tx_hold", {7'b0, bus.tx_valid}, 8'h00);
    apply_word(10'h260, 2, 1);
    apply_word(10'h300, 2, 9);
    cmp("after_rst_read", bus.dout, 8'h3A);
    $display("reset mid-transfer sequence done");

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rd = 10'($urandom);
      step(($urandom_range(0, 299) != 0), rd, ($urandom_range(0, 99) < 40));
    end
    $display("random traffic: 4000 cycles");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
